// File: rtl/nios2_oci_trace_pkg.sv
// Shared definitions for the OCI trace capture block.
// Covers the FSM state encoding, the drop counter width and the default widths.
package nios2_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_CAPTURE = 2'd0,
    ST_FROZEN  = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_e;

  localparam int DROP_W      = 16;
  localparam int TRACE_W_DEF = 30;
  localparam int COUNT_W_DEF = 4;
  localparam int DEPTH_DEF   = 16;

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// Simple dual-port trace storage with one write port and one read port.
// The read data is registered, so it appears one clock after the address is presented.
module nios2_oci_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 34,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// Captures DCT trace frames into a circular buffer, freezes capture on request,
// and then drains the frames oldest-first through a registered valid/ready output stage.
module nios2_oci_trace_capture
  import nios2_oci_trace_pkg::*;
#(
  parameter int TRACE_W   = TRACE_W_DEF,
  parameter int COUNT_W   = COUNT_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int WRAP_MODE = 1,
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [TRACE_W-1:0]         dct_buffer,
  input  logic [COUNT_W-1:0]         dct_count,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       arm,
  output logic [TRACE_W+COUNT_W-1:0] rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [LVL_W-1:0]           level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_count,
  output logic                       capturing,
  output logic                       done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = TRACE_W + COUNT_W;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  trace_state_e     state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic             drain_prime_p0;
  logic [ENT_W-1:0] rd_q_p1;
  logic             frame, full, wr_en, drop, pop;

  always_comb begin
    frame = (state == ST_CAPTURE) && (dct_count != '0) && !arm;
    full  = (level == LVL_FULL);
    wr_en = frame && (!full || (WRAP_MODE != 0));
    drop  = frame && full;
    pop   = (state == ST_DRAIN) && drain_prime_p0 && (level != '0) &&
            (!rd_valid || rd_ready) && !arm;
  end

  // The RAM is addressed with the pointer value that will be current after this edge.
  // This keeps rd_q_p1 tracking mem[rd_ptr], which is what lets back-to-back pops run with no bubble.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (reset || arm)                    rd_ptr_nxt = '0;
    else if (pop || (wr_en && full))     rd_ptr_nxt = rd_ptr + PTR_W'(1);
  end

  always_comb begin
    state_nxt = state;
    if (arm) begin
      state_nxt = ST_CAPTURE;
    end else begin
      case (state)
        ST_CAPTURE: if (test_has_ended) state_nxt = ST_DRAIN;
                    else if (test_ending) state_nxt = ST_FROZEN;
        ST_FROZEN:  if (test_has_ended) state_nxt = ST_DRAIN;
        ST_DRAIN:   if ((level == '0) && !rd_valid) state_nxt = ST_DONE;
        default:    state_nxt = ST_DONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_CAPTURE;
    else       state <= state_nxt;
  end

  assign capturing = (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);

  nios2_oci_trace_ram #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({dct_count, dct_buffer}),
    .raddr (rd_ptr_nxt),
    .rdata (rd_q_p1)
  );

  // p0: control state -- pointers, level, loss tracking and the output-stage valid.
  always_ff @(posedge clk) begin
    if (reset || arm) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      overflow       <= 1'b0;
      drop_count     <= '0;
      rd_valid       <= 1'b0;
      drain_prime_p0 <= 1'b0;
    end else begin
      rd_ptr         <= rd_ptr_nxt;
      drain_prime_p0 <= (state == ST_DRAIN);
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (frame && !full) level <= level + LVL_W'(1);
      else if (pop)       level <= level - LVL_W'(1);
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= sat_inc(drop_count);
      end
      if (pop)                      rd_valid <= 1'b1;
      else if (rd_valid && rd_ready) rd_valid <= 1'b0;
    end
  end

  // p1: output data register, loaded from the RAM read port on each pop.
  always_ff @(posedge clk) begin
    if (reset)    rd_data <= '0;
    else if (pop) rd_data <= rd_q_p1;
  end

endmodule

// File: tb/tb_nios2_oci_trace_capture.sv
// Directed bench for nios2_oci_trace_capture: two instances (wrap / no-wrap) share the stimulus.
module tb_nios2_oci_trace_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] dct_buffer = '0;
  logic [3:0]  dct_count = '0;
  logic        test_ending = 1'b0;
  logic        test_has_ended = 1'b0;
  logic        arm = 1'b0;
  logic        rd_ready = 1'b0;

  logic [33:0] w_rd_data, n_rd_data;
  logic        w_rd_valid, n_rd_valid;
  logic [4:0]  w_level, n_level;
  logic        w_overflow, n_overflow;
  logic [15:0] w_drop_count, n_drop_count;
  logic        w_capturing, n_capturing;
  logic        w_done, n_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nios2_oci_trace_capture #(.TRACE_W(30), .COUNT_W(4), .DEPTH(16), .WRAP_MODE(1)) dut_w (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .arm(arm),
    .rd_data(w_rd_data), .rd_valid(w_rd_valid), .rd_ready(rd_ready), .level(w_level),
    .overflow(w_overflow), .drop_count(w_drop_count), .capturing(w_capturing), .done(w_done)
  );

  nios2_oci_trace_capture #(.TRACE_W(30), .COUNT_W(4), .DEPTH(16), .WRAP_MODE(0)) dut_n (
    .clk(clk), .reset(reset), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .test_ending(test_ending), .test_has_ended(test_has_ended), .arm(arm),
    .rd_data(n_rd_data), .rd_valid(n_rd_valid), .rd_ready(rd_ready), .level(n_level),
    .overflow(n_overflow), .drop_count(n_drop_count), .capturing(n_capturing), .done(n_done)
  );

  function automatic logic [33:0] ent(input int c, input int b);
    return {4'(c), 30'(b)};
  endfunction

  function automatic logic [3:0] cnt(input int i);
    return 4'(((i - 1) % 15) + 1);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; arm = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    dct_count = '0; dct_buffer = '0; rd_ready = 1'b0;
    step; step;
    reset = 1'b0;
  endtask

  task automatic send(input int i, input logic [3:0] c);
    dct_count = c; dct_buffer = 30'(i);
    step;
    dct_count = '0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (w_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", w_level); end
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", w_rd_valid); end
    checks++; if (w_rd_data !== 34'd0) begin failures++; $display("FAIL reset_rd_data got=%0h exp=0", w_rd_data); end
    checks++; if (w_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", w_overflow); end
    checks++; if (w_drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop_count got=%0d exp=0", w_drop_count); end
    checks++; if (w_capturing !== 1'b1 || n_capturing !== 1'b1) begin failures++; $display("FAIL reset_capturing got=%0b/%0b exp=1", w_capturing, n_capturing); end
    checks++; if (w_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", w_done); end
  endtask

  task automatic test_basic;
    do_reset;
    rd_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(i, 4'(i));
    checks++; if (w_level !== 5'd5) begin failures++; $display("FAIL basic_level got=%0d exp=5", w_level); end
    test_ending = 1'b1; step; test_ending = 1'b0;
    checks++; if (w_capturing !== 1'b0) begin failures++; $display("FAIL basic_frozen got=%0b exp=0", w_capturing); end
    test_has_ended = 1'b1; step; test_has_ended = 1'b0;
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL basic_lat1 got=%0b exp=0", w_rd_valid); end
    step;
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL basic_lat2 got=%0b exp=0", w_rd_valid); end
    step;
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (w_rd_valid !== 1'b1 || w_rd_data !== ent(k, k)) begin
        failures++; $display("FAIL basic_word%0d got=%0b/%0h exp=1/%0h", k, w_rd_valid, w_rd_data, ent(k, k));
      end
      step;
    end
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_drop got=%0b exp=0", w_rd_valid); end
    step;
    checks++; if (w_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", w_done); end
    checks++; if (w_overflow !== 1'b0) begin failures++; $display("FAIL basic_overflow got=%0b exp=0", w_overflow); end
  endtask

  task automatic test_wrap;
    do_reset;
    rd_ready = 1'b1;
    for (int i = 1; i <= 20; i++) send(i, cnt(i));
    checks++; if (w_level !== 5'd16) begin failures++; $display("FAIL wrap_level got=%0d exp=16", w_level); end
    checks++; if (w_overflow !== 1'b1) begin failures++; $display("FAIL wrap_overflow got=%0b exp=1", w_overflow); end
    checks++; if (w_drop_count !== 16'd4) begin failures++; $display("FAIL wrap_drop_count got=%0d exp=4", w_drop_count); end
    test_has_ended = 1'b1; step; test_has_ended = 1'b0;
    step; step;
    for (int j = 5; j <= 20; j++) begin
      checks++;
      if (w_rd_valid !== 1'b1 || w_rd_data !== ent(cnt(j), j)) begin
        failures++; $display("FAIL wrap_word%0d got=%0b/%0h exp=1/%0h", j, w_rd_valid, w_rd_data, ent(cnt(j), j));
      end
      step;
    end
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL wrap_end_valid got=%0b exp=0", w_rd_valid); end
    step;
    checks++; if (w_done !== 1'b1) begin failures++; $display("FAIL wrap_done got=%0b exp=1", w_done); end
  endtask

  task automatic test_nowrap;
    do_reset;
    rd_ready = 1'b1;
    for (int i = 1; i <= 20; i++) send(i, cnt(i));
    checks++; if (n_level !== 5'd16) begin failures++; $display("FAIL nowrap_level got=%0d exp=16", n_level); end
    checks++; if (n_overflow !== 1'b1) begin failures++; $display("FAIL nowrap_overflow got=%0b exp=1", n_overflow); end
    checks++; if (n_drop_count !== 16'd4) begin failures++; $display("FAIL nowrap_drop_count got=%0d exp=4", n_drop_count); end
    test_has_ended = 1'b1; step; test_has_ended = 1'b0;
    step; step;
    for (int j = 1; j <= 16; j++) begin
      checks++;
      if (n_rd_valid !== 1'b1 || n_rd_data !== ent(cnt(j), j)) begin
        failures++; $display("FAIL nowrap_word%0d got=%0b/%0h exp=1/%0h", j, n_rd_valid, n_rd_data, ent(cnt(j), j));
      end
      step;
    end
    checks++; if (n_rd_valid !== 1'b0) begin failures++; $display("FAIL nowrap_end_valid got=%0b exp=0", n_rd_valid); end
    step;
    checks++; if (n_done !== 1'b1) begin failures++; $display("FAIL nowrap_done got=%0b exp=1", n_done); end
  endtask

  task automatic test_backpressure;
    int pat [4] = '{1, 0, 0, 1};
    int idx = 0;
    int stalls = 0;
    logic v, r;
    logic [33:0] d;
    do_reset;
    for (int i = 1; i <= 4; i++) send(i, 4'(i));
    test_ending = 1'b1; step; test_ending = 1'b0;
    test_has_ended = 1'b1; step; test_has_ended = 1'b0;
    for (int c = 0; c < 40; c++) begin
      rd_ready = pat[c % 4][0];
      v = w_rd_valid; r = rd_ready; d = w_rd_data;
      step;
      if (v && r) begin
        checks++;
        if (d !== ent(idx + 1, idx + 1)) begin
          failures++; $display("FAIL bp_word%0d got=%0h exp=%0h", idx + 1, d, ent(idx + 1, idx + 1));
        end
        idx++;
      end else if (v) begin
        stalls++;
        checks++;
        if (w_rd_valid !== 1'b1 || w_rd_data !== d) begin
          failures++; $display("FAIL bp_hold got=%0b/%0h exp=1/%0h", w_rd_valid, w_rd_data, d);
        end
      end
    end
    rd_ready = 1'b0;
    checks++; if (idx !== 4) begin failures++; $display("FAIL bp_word_count got=%0d exp=4", idx); end
    checks++; if (stalls < 1) begin failures++; $display("FAIL bp_stalls got=%0d exp>=1", stalls); end
    checks++; if (w_done !== 1'b1) begin failures++; $display("FAIL bp_done got=%0b exp=1", w_done); end
  endtask

  task automatic test_end_same_cycle;
    do_reset;
    send(1, 4'd1);
    send(2, 4'd2);
    dct_count = 4'd3; dct_buffer = 30'd3; test_ending = 1'b1;
    step;
    test_ending = 1'b0; dct_count = 4'd4; dct_buffer = 30'd4;
    step;
    dct_count = '0;
    checks++; if (w_level !== 5'd3) begin failures++; $display("FAIL same_cycle_level got=%0d exp=3", w_level); end
    checks++; if (w_capturing !== 1'b0) begin failures++; $display("FAIL same_cycle_capturing got=%0b exp=0", w_capturing); end
    checks++; if (w_drop_count !== 16'd0) begin failures++; $display("FAIL same_cycle_drops got=%0d exp=0", w_drop_count); end
    rd_ready = 1'b1;
    test_has_ended = 1'b1; step; test_has_ended = 1'b0;
    step; step; step; step;
    checks++; if (w_rd_data !== ent(3, 3)) begin failures++; $display("FAIL same_cycle_last got=%0h exp=%0h", w_rd_data, ent(3, 3)); end
    step;
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL same_cycle_extra got=%0b exp=0", w_rd_valid); end
  endtask

  task automatic test_reset_mid_drain_arm;
    do_reset;
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) send(i, 4'(i));
    test_has_ended = 1'b1; step; test_has_ended = 1'b0;
    step; step; step; step;
    checks++; if (w_rd_data !== ent(3, 3)) begin failures++; $display("FAIL mid_drain_word got=%0h exp=%0h", w_rd_data, ent(3, 3)); end
    reset = 1'b1; step; reset = 1'b0;
    checks++; if (w_level !== 5'd0) begin failures++; $display("FAIL mid_reset_level got=%0d exp=0", w_level); end
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid got=%0b exp=0", w_rd_valid); end
    checks++; if (w_rd_data !== 34'd0) begin failures++; $display("FAIL mid_reset_data got=%0h exp=0", w_rd_data); end
    checks++; if (w_capturing !== 1'b1 || w_done !== 1'b0) begin failures++; $display("FAIL mid_reset_state got=%0b/%0b exp=1/0", w_capturing, w_done); end
    test_has_ended = 1'b1; step; test_has_ended = 1'b0;
    checks++; if (w_capturing !== 1'b0 || w_done !== 1'b0) begin failures++; $display("FAIL empty_drain_state got=%0b/%0b exp=0/0", w_capturing, w_done); end
    step;
    checks++; if (w_done !== 1'b1) begin failures++; $display("FAIL empty_drain_done got=%0b exp=1", w_done); end
    checks++; if (w_rd_valid !== 1'b0) begin failures++; $display("FAIL empty_drain_valid got=%0b exp=0", w_rd_valid); end
    arm = 1'b1; step; arm = 1'b0;
    checks++; if (w_capturing !== 1'b1 || w_done !== 1'b0) begin failures++; $display("FAIL arm_state got=%0b/%0b exp=1/0", w_capturing, w_done); end
    checks++; if (w_level !== 5'd0) begin failures++; $display("FAIL arm_level got=%0d exp=0", w_level); end
    send(7, 4'd7);
    checks++; if (w_level !== 5'd1) begin failures++; $display("FAIL arm_recapture got=%0d exp=1", w_level); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_nowrap;
    test_backpressure;
    test_end_same_cycle;
    test_reset_mid_drain_arm;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
